// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit that sits beside the ALU.
// Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring
// shift-subtract. Both run on operand magnitudes, and the sign is fixed up once
// on the transition into DONE.
// Optional build macro: MULDIV_FAST_MUL_EN. When it is defined, multiplies use
// a combinational 2*WIDTH multiplier and finish one cycle after they are
// accepted.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Architectural state
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_abs_a;
  logic [WIDTH-1:0] r_abs_b;
  logic             r_neg;      // negate product / quotient
  logic             r_sign_a;   // remainder takes dividend sign
  logic [W2-1:0]    r_acc;      // mul: {hi, multiplier}; div: low half is quotient
  logic [WIDTH:0]   r_rem;      // partial remainder, one extra bit for the carry
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [2:0]       w_op_nxt;
  logic [WIDTH-1:0] w_abs_a_nxt;
  logic [WIDTH-1:0] w_abs_b_nxt;
  logic             w_neg_nxt;
  logic             w_sign_a_nxt;
  logic [W2-1:0]    w_acc_nxt;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_result_nxt;

  // Operand decode
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a_in;
  logic [WIDTH-1:0] w_abs_b_in;
  logic             w_div_zero;
  logic             w_div_ovf;

  // Iteration datapath
  logic [WIDTH:0]   w_mul_sum;
  logic [W2-1:0]    w_mul_acc;
  logic [WIDTH+1:0] w_div_shift;
  logic [WIDTH+1:0] w_div_diff;
  logic             w_div_borrow;
  logic [W2-1:0]    w_div_acc;
  logic [WIDTH:0]   w_div_rem;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_remv;
  logic [WIDTH-1:0] w_fix_result;

`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0]    w_fast_a;
  logic [W2-1:0]    w_fast_b;
  logic [W2-1:0]    w_fast_prod;

  // Single-cycle multiply of the sign- or zero-extended operands
  always_comb begin
    w_fast_a    = {{WIDTH{w_a_signed & a[WIDTH-1]}}, a};
    w_fast_b    = {{WIDTH{w_b_signed & b[WIDTH-1]}}, b};
    w_fast_prod = w_fast_a * w_fast_b;
  end
`endif

  // Decode the operand signedness of the requested op, and detect the special cases
  always_comb begin
    w_a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                 (op == OP_DIV) || (op == OP_REM);
    w_b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                 (op == OP_DIV) || (op == OP_REM);
    w_a_neg    = w_a_signed & a[WIDTH-1];
    w_b_neg    = w_b_signed & b[WIDTH-1];
    // Negating MIN_NEG wraps to MIN_NEG, which is the correct unsigned magnitude
    w_abs_a_in = w_a_neg ? (~a + WIDTH'(1)) : a;
    w_abs_b_in = w_b_neg ? (~b + WIDTH'(1)) : b;
    w_div_zero = op[2] & (b == '0);
    w_div_ovf  = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);
  end

  // One shift-add step, and one restoring shift-subtract step
  always_comb begin
    w_mul_sum    = {1'b0, r_acc[W2-1:WIDTH]} +
                   (r_acc[0] ? {1'b0, r_abs_a} : {(WIDTH+1){1'b0}});
    w_mul_acc    = {w_mul_sum, r_acc[WIDTH-1:1]};

    w_div_shift  = {r_rem, r_acc[WIDTH-1]};
    w_div_diff   = w_div_shift - {2'b00, r_abs_b};
    w_div_borrow = w_div_diff[WIDTH+1];
    w_div_acc    = {r_acc[W2-1:WIDTH], r_acc[WIDTH-2:0], ~w_div_borrow};
    w_div_rem    = w_div_borrow ? w_div_shift[WIDTH:0] : w_div_diff[WIDTH:0];
  end

  // Sign fix-up of the final iteration's outputs, then result selection
  always_comb begin
    w_prod = r_neg ? (~w_mul_acc + W2'(1)) : w_mul_acc;
    w_quo  = r_neg ? (~w_div_acc[WIDTH-1:0] + WIDTH'(1)) : w_div_acc[WIDTH-1:0];
    w_remv = r_sign_a ? (~w_div_rem[WIDTH-1:0] + WIDTH'(1)) : w_div_rem[WIDTH-1:0];
    if (r_op[2]) begin
      w_fix_result = r_op[1] ? w_remv : w_quo;
    end else begin
      w_fix_result = (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[W2-1:WIDTH];
    end
  end

  // Next-state logic and registered output values
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_abs_a_nxt  = r_abs_a;
    w_abs_b_nxt  = r_abs_b;
    w_neg_nxt    = r_neg;
    w_sign_a_nxt = r_sign_a;
    w_acc_nxt    = r_acc;
    w_rem_nxt    = r_rem;
    w_result_nxt = r_result;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op_nxt     = op;
          w_abs_a_nxt  = w_abs_a_in;
          w_abs_b_nxt  = w_abs_b_in;
          w_neg_nxt    = w_a_neg ^ w_b_neg;
          w_sign_a_nxt = w_a_neg;
          w_acc_nxt    = op[2] ? {{WIDTH{1'b0}}, w_abs_a_in} : {{WIDTH{1'b0}}, w_abs_b_in};
          w_rem_nxt    = '0;
          w_cnt_nxt    = CW'(WIDTH);
          if (w_div_zero) begin
            w_result_nxt = op[1] ? a : '1;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_DONE;
          end else if (w_div_ovf) begin
            w_result_nxt = op[1] ? '0 : MIN_NEG;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op[2]) begin
            w_result_nxt = (op[1:0] == 2'b00) ? w_fast_prod[WIDTH-1:0]
                                              : w_fast_prod[W2-1:WIDTH];
            w_cnt_nxt    = '0;
            w_state_nxt  = S_DONE;
`endif
          end else begin
            w_state_nxt  = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_cnt_nxt = r_cnt - CW'(1);
        w_acc_nxt = r_op[2] ? w_div_acc : w_mul_acc;
        w_rem_nxt = r_op[2] ? w_div_rem : r_rem;
        if (r_cnt == CW'(1)) begin
          w_result_nxt = w_fix_result;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_abs_a  <= '0;
      r_abs_b  <= '0;
      r_neg    <= 1'b0;
      r_sign_a <= 1'b0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_abs_a  <= w_abs_a_nxt;
      r_abs_b  <= w_abs_b_nxt;
      r_neg    <= w_neg_nxt;
      r_sign_a <= w_sign_a_nxt;
      r_acc    <= w_acc_nxt;
      r_rem    <= w_rem_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, hand-written timing sequences and
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int ITER_LAT = 33;
  localparam int NVEC     = 18;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [NVEC];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] t_op, input logic [31:0] t_a,
                                             input logic [31:0] t_b);
    logic signed [65:0] ea;
    logic signed [65:0] eb;
    logic signed [65:0] p;
    int sa;
    int sb;
    if (!t_op[2]) begin
      ea = (t_op == OP_MULHU) ? $signed({34'd0, t_a}) : $signed({{34{t_a[31]}}, t_a});
      eb = (t_op == OP_MULHU || t_op == OP_MULHSU) ? $signed({34'd0, t_b})
                                                   : $signed({{34{t_b[31]}}, t_b});
      p  = ea * eb;
      return (t_op == OP_MUL) ? p[31:0] : p[63:32];
    end
    if (t_b == 32'd0) return t_op[1] ? t_a : 32'hFFFF_FFFF;
    if (!t_op[0]) begin
      if (t_a == 32'h8000_0000 && t_b == 32'hFFFF_FFFF)
        return t_op[1] ? 32'd0 : 32'h8000_0000;
      sa = t_a;
      sb = t_b;
      return t_op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return t_op[1] ? (t_a % t_b) : (t_a / t_b);
  endfunction

  function automatic int ref_latency(input logic [2:0] t_op, input logic [31:0] t_a,
                                     input logic [31:0] t_b);
    if (!t_op[2]) return MUL_LAT;
    if (t_b == 32'd0) return 1;
    if (!t_op[0] && t_a == 32'h8000_0000 && t_b == 32'hFFFF_FFFF) return 1;
    return ITER_LAT;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op in the current IDLE cycle and check the latency, the busy window, the result and its hold
  task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 1;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cyc <= 80) begin
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(cyc), 32'(exp_lat));
      check("result", result, exp_res);
      check("busy_window", 32'(busy_ok), 32'd1);
    end
    @(posedge clk);
    #1;
    check("idle_after", {30'd0, busy, done}, 32'd0);
    check("result_hold", result, exp_res);
  endtask

  initial begin
    int cyc;
    int done_at;
    bit stray;
    bit no_done;
    logic [31:0] res_at;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
    vecs[2]  = '{OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT};
    vecs[3]  = '{OP_MULHU,  32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, MUL_LAT};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, ITER_LAT};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, ITER_LAT};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        ITER_LAT};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         ITER_LAT};
    vecs[8]  = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{OP_DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, ITER_LAT};
    vecs[13] = '{OP_REMU,   32'hFFFF_FFFF,  32'h8000_0000, 32'h7FFF_FFFF, ITER_LAT};
    vecs[14] = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[15] = '{OP_REMU,   32'h1234_5678,  32'd0,         32'h1234_5678, 1};
    vecs[16] = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[17] = '{OP_MUL,    32'h8000_0000,  32'h8000_0000, 32'd0,         MUL_LAT};

    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Starts during CALC and during DONE are ignored; start in the next cycle is accepted
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd1000;
    b     = 32'hFFFF_FFF9;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 1;
    stray   = 1'b0;
    done_at = 0;
    while (cyc < 34) begin
      if (cyc == 5 || cyc == 33) begin
        start = 1'b1;
        op    = OP_MUL;
        a     = 32'd3;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        if (cyc == 33) begin
          done_at = cyc;
          check("ignored_start_result", result, 32'hFFFF_FF72);
        end else begin
          stray = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("ignored_start_done_cycle", 32'(done_at), 32'd33);
    check("ignored_start_stray_done", 32'(stray), 32'd0);
    // cycle 34: first IDLE cycle after DONE
    check("b2b_idle", {30'd0, busy, done}, 32'd0);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 35;
    done_at = 0;
    res_at  = '0;
    while (cyc <= 70 && done_at == 0) begin
      if (done) begin
        done_at = cyc;
        res_at  = result;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check("b2b_done_cycle", 32'(done_at), 32'd67);
    check("b2b_result", res_at, 32'd14);
    @(posedge clk);
    #1;

    // Reset mid-divide clears the outputs at once, and no done follows
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    no_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) no_done = 1'b0;
    end
    check("abort_no_done", 32'(no_done), 32'd1);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, ref_result(rop, ra, rb), ref_latency(rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the single-cycle core's execute path, beside the ALU.
- Its result feeds the writeback result-select mux on a dedicated input.
- The control unit stalls PC and register-file write while busy is high, then writes rd on the done pulse.
- Covers all eight M-extension ops selected by funct3.

Parameters:
WIDTH, 32, operand/result width; counter width is clog2(WIDTH)+1.

Ports:
clk  input  1  core clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE.
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
a  input  WIDTH  rs1 operand, latched on accept.
b  input  WIDTH  rs2 operand, latched on accept.
busy  output  1  high from the accept edge until done deasserts.
done  output  1  one-cycle pulse; result valid in the same cycle.
result  output  WIDTH  final value; held until the next done.

Behaviour:
- Reset is asynchronous on rst_n low, from any state. State goes to IDLE; busy=0, done=0, result=0, counter=0; internal operand and accumulator registers are cleared.
- States:
  - IDLE: start=1 latches op, a and b. It also latches sign flags and absolute values per op. MUL, MULH and DIV/REM treat both operands as signed. MULHSU treats a as signed, b as unsigned. MULHU, DIVU and REMU treat both as unsigned. The next state is CALC, or DONE on a special case. busy=1 from the next cycle.
  - CALC: one iteration per cycle for exactly WIDTH cycles. The counter counts down from WIDTH and leaves for DONE when it reaches 1.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract giving quotient and remainder.
  - DONE: done=1, busy=1, result registered. Always goes to IDLE the next cycle. busy falls together with done.
- Latency: accept edge at cycle 0, done high at cycle WIDTH+1 (33). Special cases have done high at cycle 1.
- A start outside IDLE is ignored, with no queueing. A start in the same cycle as done is also ignored. Back-to-back accept is possible in the first IDLE cycle after DONE.
- Sign fix-up, applied once in the CALC-to-DONE transition:
  - 64-bit product is negated if the operand signs differ.
  - MUL returns the low word. MULH, MULHSU and MULHU return the high word.
  - Quotient is negated if signs differ; remainder takes the sign of the dividend.
- Special cases skip CALC (IDLE to DONE):
  - Divide by zero (b=0): DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - Multiply has no special cases.
- Widths:
  - Absolute value of 0x80000000 is held as unsigned 0x80000000 without error.
  - The divide remainder register is WIDTH+1 bits, so the subtract carry is visible.
- result changes only on the DONE entry edge. busy and done are registered outputs, not combinational from start.
- Reset asserted during CALC aborts the operation with no done. The first start after release behaves normally.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined:
  - All multiply ops use a combinational signed/unsigned 2*WIDTH multiply and go IDLE to DONE, so done is high at cycle 1.
  - Divide ops remain iterative at 33 cycles.
- Undefined:
  - Multiply uses the iterative CALC path at 33 cycles.
  - No combinational multiplier is instantiated.

Test Plan:
- Reset, then MUL with a=7, b=-3 (0xFFFFFFFD) -> done at cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN), result=0xFFFFFFEB; busy high for cycles 1..33.
- MULH, MULHSU, MULHU each with a=0x80000000, b=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0x80000000.
  - MULHU -> 0x7FFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2. All with done at cycle 33.
- DIVU a=5, b=0 -> 0xFFFFFFFF at cycle 1; REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000 at cycle 1; REM of the same operands -> 0.
- start pulses at cycles 5 and 33 during an active DIV -> ignored; result and timing unchanged. New start at cycle 34 accepted; its done at cycle 67.
- rst_n pulsed low at cycle 10 of a DIV -> busy=0, done=0, result=0 immediately. No done ever follows. Fresh MULHU a=b=0xFFFFFFFF after release -> 0xFFFFFFFE.
